// File: rtl/svm_multi_classifier_if.sv
// Model/sample input channel and result output channel of svm_multi_classifier.
// master: drives model beats and dout_ready (the producer/consumer side).
// slave : the classifier engine.
//   in_features  : F_WIDTH signed features, feature f at [f*NBITS +: NBITS]
//   in_support   : support vector s, feature f at [(s*F_WIDTH+f)*NBITS +: NBITS]
//   in_alpha     : signed dual coefficients, alpha s at [s*NBITS +: NBITS]
//   in_intercept : signed bias for the class being loaded
//   in_nsup      : active support vectors for the class being loaded
//   fin_valid/fin_ready   : model beat handshake
//   busy                  : engine is inside a frame
//   dout_labels/dout_scores/dout_valid/dout_ready : result beat handshake
interface svm_multi_classifier_if #(
    parameter int NBITS     = 5,
    parameter int F_WIDTH   = 2,
    parameter int SUP_WIDTH = 164,
    parameter int NCLASS    = 2
);
    localparam int LOG_F_WIDTH   = $clog2(F_WIDTH);
    localparam int LOG_SUP_WIDTH = $clog2(SUP_WIDTH);
    localparam int S_W           = 3*NBITS + LOG_F_WIDTH + LOG_SUP_WIDTH + 1;

    logic [NBITS*F_WIDTH-1:0]           in_features;
    logic [NBITS*SUP_WIDTH*F_WIDTH-1:0] in_support;
    logic [NBITS*SUP_WIDTH-1:0]         in_alpha;
    logic [S_W-1:0]                     in_intercept;
    logic [LOG_SUP_WIDTH:0]             in_nsup;
    logic                               fin_valid;
    logic                               fin_ready;
    logic                               busy;
    logic [NCLASS-1:0]                  dout_labels;
    logic [NCLASS*S_W-1:0]              dout_scores;
    logic                               dout_valid;
    logic                               dout_ready;

    modport master (
        output in_features, in_support, in_alpha, in_intercept, in_nsup,
        output fin_valid, dout_ready,
        input  fin_ready, busy, dout_labels, dout_scores, dout_valid
    );

    modport slave (
        input  in_features, in_support, in_alpha, in_intercept, in_nsup,
        input  fin_valid, dout_ready,
        output fin_ready, busy, dout_labels, dout_scores, dout_valid
    );
endinterface

// File: rtl/svm_multi_classifier.sv
// NCLASS one-vs-rest linear SVM engine. One model beat per class is accepted
// in LOAD; MAT1 builds kern[s] = <support[s], features> NPARALLEL vectors at a
// time, MAT2 accumulates sum(kern[s]*alpha[s]), CMP adds the intercept and
// stores label/score for the class. After the last class all labels and
// scores are presented in one beat in OUT and held until dout_ready.
// Ports:
//   clk  : clock
//   rst  : asynchronous reset, active-high
//   bus  : svm_multi_classifier_if.slave (model input and result output)
module svm_multi_classifier #(
    parameter int NBITS         = 5,
    parameter int F_WIDTH       = 2,
    parameter int LOG_F_WIDTH   = $clog2(F_WIDTH),
    parameter int SUP_WIDTH     = 164,
    parameter int LOG_SUP_WIDTH = $clog2(SUP_WIDTH),
    parameter int NPARALLEL     = 4,
    parameter int NCLASS        = 2,
    parameter int S_W           = 3*NBITS + LOG_F_WIDTH + LOG_SUP_WIDTH + 1
) (
    input logic                  clk,
    input logic                  rst,
    svm_multi_classifier_if.slave bus
);
    localparam int PROD_W = 2*NBITS;
    localparam int KERN_W = 2*NBITS + LOG_F_WIDTH;
    localparam int MAC_W  = KERN_W + NBITS;
    localparam int NSUP_W = LOG_SUP_WIDTH + 1;
    localparam int IDX_W  = (LOG_SUP_WIDTH > 0) ? LOG_SUP_WIDTH : 1;
    localparam int FIDX_W = (LOG_F_WIDTH > 0) ? LOG_F_WIDTH : 1;
    localparam int CLS_W  = ($clog2(NCLASS) > 0) ? $clog2(NCLASS) : 1;
    localparam int CNT_W  = $clog2(SUP_WIDTH + NPARALLEL) + 1;

    localparam logic [2:0] S_LOAD = 3'd0;
    localparam logic [2:0] S_MAT1 = 3'd1;
    localparam logic [2:0] S_MAT2 = 3'd2;
    localparam logic [2:0] S_CMP  = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;

    logic [2:0]               r_state;
    logic [CLS_W-1:0]         r_class_idx;
    logic [NSUP_W-1:0]        r_nsup;
    logic [CNT_W-1:0]         r_sidx;
    logic [FIDX_W-1:0]        r_fidx;
    logic signed [NBITS-1:0]  r_feat  [F_WIDTH];
    logic signed [NBITS-1:0]  r_sup   [SUP_WIDTH][F_WIDTH];
    logic signed [NBITS-1:0]  r_alpha [SUP_WIDTH];
    logic signed [S_W-1:0]    r_icpt;
    logic signed [KERN_W-1:0] r_kern  [SUP_WIDTH];
    logic signed [S_W-1:0]    r_score;
    logic [NCLASS-1:0]        r_labels;
    logic [NCLASS*S_W-1:0]    r_scores;

    logic                     w_accept;
    logic [NSUP_W-1:0]        w_nsup_clamped;
    logic                     w_lane_en  [NPARALLEL];
    logic [IDX_W-1:0]         w_lane_sel [NPARALLEL];
    logic signed [PROD_W-1:0] w_prod     [NPARALLEL];
    logic [IDX_W-1:0]         w_mac_sel;
    logic signed [MAC_W-1:0]  w_mac;
    logic signed [S_W-1:0]    w_score_c;

    assign w_accept       = bus.fin_valid && (r_state == S_LOAD);
    assign w_nsup_clamped = (32'(bus.in_nsup) > SUP_WIDTH) ? NSUP_W'(SUP_WIDTH) : bus.in_nsup;

    // Lanes past nsup are parked on index 0 and masked off, so the
    // multiplier inputs never select beyond the support array.
    always_comb begin
        for (int unsigned p = 0; p < NPARALLEL; p++) begin
            w_lane_en[p]  = (32'(r_sidx) + p) < 32'(r_nsup);
            w_lane_sel[p] = w_lane_en[p] ? IDX_W'(32'(r_sidx) + p) : '0;
            w_prod[p]     = PROD_W'(r_sup[w_lane_sel[p]][r_fidx]) * PROD_W'(r_feat[r_fidx]);
        end
    end

    always_comb begin
        w_mac_sel = IDX_W'(r_sidx);
        w_mac     = MAC_W'(r_kern[w_mac_sel]) * MAC_W'(r_alpha[w_mac_sel]);
        w_score_c = r_score + r_icpt;
    end

    // Model registers carry no reset; they are only read after a fresh load.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int unsigned f = 0; f < F_WIDTH; f++) begin
                r_feat[f] <= bus.in_features[f*NBITS +: NBITS];
            end
            for (int unsigned s = 0; s < SUP_WIDTH; s++) begin
                r_alpha[s] <= bus.in_alpha[s*NBITS +: NBITS];
                for (int unsigned f = 0; f < F_WIDTH; f++) begin
                    r_sup[s][f] <= bus.in_support[(s*F_WIDTH + f)*NBITS +: NBITS];
                end
            end
            r_icpt <= bus.in_intercept;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_LOAD;
            r_class_idx <= '0;
            r_nsup      <= '0;
            r_sidx      <= '0;
            r_fidx      <= '0;
            r_score     <= '0;
            r_labels    <= '0;
            r_scores    <= '0;
            for (int unsigned s = 0; s < SUP_WIDTH; s++) begin
                r_kern[s] <= '0;
            end
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (bus.fin_valid) begin
                        r_nsup  <= w_nsup_clamped;
                        r_sidx  <= '0;
                        r_fidx  <= '0;
                        r_score <= '0;
                        for (int unsigned s = 0; s < SUP_WIDTH; s++) begin
                            r_kern[s] <= '0;
                        end
                        r_state <= (w_nsup_clamped == '0) ? S_CMP : S_MAT1;
                    end
                end
                S_MAT1: begin
                    for (int unsigned p = 0; p < NPARALLEL; p++) begin
                        if (w_lane_en[p]) begin
                            r_kern[w_lane_sel[p]] <= r_kern[w_lane_sel[p]] + KERN_W'(w_prod[p]);
                        end
                    end
                    if (r_fidx == FIDX_W'(F_WIDTH - 1)) begin
                        r_fidx <= '0;
                        if (32'(r_sidx) + NPARALLEL >= 32'(r_nsup)) begin
                            r_sidx  <= '0;
                            r_state <= S_MAT2;
                        end else begin
                            r_sidx <= r_sidx + CNT_W'(NPARALLEL);
                        end
                    end else begin
                        r_fidx <= r_fidx + FIDX_W'(1);
                    end
                end
                S_MAT2: begin
                    r_score <= r_score + S_W'(w_mac);
                    if (32'(r_sidx) + 1 >= 32'(r_nsup)) begin
                        r_state <= S_CMP;
                    end else begin
                        r_sidx <= r_sidx + CNT_W'(1);
                    end
                end
                S_CMP: begin
                    r_scores[32'(r_class_idx)*S_W +: S_W] <= w_score_c;
                    // Strictly positive: a zero score maps to label 0.
                    r_labels[r_class_idx] <= !w_score_c[S_W-1] && (w_score_c != '0);
                    if (r_class_idx == CLS_W'(NCLASS - 1)) begin
                        r_state <= S_OUT;
                    end else begin
                        r_class_idx <= r_class_idx + CLS_W'(1);
                        r_state     <= S_LOAD;
                    end
                end
                S_OUT: begin
                    if (bus.dout_ready) begin
                        r_class_idx <= '0;
                        r_state     <= S_LOAD;
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    assign bus.fin_ready   = (r_state == S_LOAD);
    assign bus.dout_valid  = (r_state == S_OUT);
    assign bus.busy        = !((r_state == S_LOAD) && (r_class_idx == '0));
    assign bus.dout_labels = r_labels;
    assign bus.dout_scores = r_scores;
endmodule

// File: tb/tb_svm_multi_classifier.sv
// Directed and randomized checks of svm_multi_classifier against a plain
// arithmetic reference (dot products, clamped support count, block latency).
module tb_svm_multi_classifier;
    localparam int NBITS     = 5;
    localparam int F_WIDTH   = 2;
    localparam int SUP_WIDTH = 4;
    localparam int NPARALLEL = 3;
    localparam int NCLASS    = 2;
    localparam int S_W       = 3*NBITS + $clog2(F_WIDTH) + $clog2(SUP_WIDTH) + 1;
    localparam int NSUP_W    = $clog2(SUP_WIDTH) + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    svm_multi_classifier_if #(
        .NBITS(NBITS), .F_WIDTH(F_WIDTH), .SUP_WIDTH(SUP_WIDTH), .NCLASS(NCLASS)
    ) bus ();

    svm_multi_classifier #(
        .NBITS(NBITS), .F_WIDTH(F_WIDTH), .SUP_WIDTH(SUP_WIDTH),
        .NPARALLEL(NPARALLEL), .NCLASS(NCLASS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int feat  [F_WIDTH];
    int sup   [SUP_WIDTH][F_WIDTH];
    int alpha [SUP_WIDTH];
    int exp_sc [NCLASS];
    int prev_sc1 = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int rnd5();
        return int'($urandom_range(31)) - 16;
    endfunction

    function automatic int dut_score(input int c);
        logic signed [S_W-1:0] v;
        v = bus.dout_scores[c*S_W +: S_W];
        return int'(v);
    endfunction

    function automatic int clamp_n(input int n);
        return (n > SUP_WIDTH) ? SUP_WIDTH : n;
    endfunction

    function automatic int ref_score(input int n, input int icpt);
        int acc, dot;
        acc = icpt;
        for (int s = 0; s < clamp_n(n); s++) begin
            dot = 0;
            for (int f = 0; f < F_WIDTH; f++) dot += sup[s][f] * feat[f];
            acc += alpha[s] * dot;
        end
        return acc;
    endfunction

    function automatic int ref_latency(input int n);
        int nn;
        nn = clamp_n(n);
        if (nn == 0) return 1;
        return ((nn + NPARALLEL - 1) / NPARALLEL) * F_WIDTH + nn + 1;
    endfunction

    function automatic int exp_labels();
        int v;
        v = 0;
        for (int c = 0; c < NCLASS; c++) if (exp_sc[c] > 0) v |= (1 << c);
        return v;
    endfunction

    task automatic rand_data();
        for (int f = 0; f < F_WIDTH; f++) feat[f] = rnd5();
        for (int s = 0; s < SUP_WIDTH; s++) begin
            alpha[s] = rnd5();
            for (int f = 0; f < F_WIDTH; f++) sup[s][f] = rnd5();
        end
    endtask

    task automatic scramble();
        bus.in_features  = (NBITS*F_WIDTH)'($urandom());
        bus.in_support   = (NBITS*SUP_WIDTH*F_WIDTH)'({$urandom(), $urandom()});
        bus.in_alpha     = (NBITS*SUP_WIDTH)'($urandom());
        bus.in_intercept = S_W'($urandom());
        bus.in_nsup      = NSUP_W'($urandom());
    endtask

    task automatic send_beat(input int c, input int n, input int icpt);
        int k;
        k = 0;
        @(negedge clk);
        while (!bus.fin_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("fin_ready_wait", int'(bus.fin_ready), 1);
        for (int f = 0; f < F_WIDTH; f++) bus.in_features[f*NBITS +: NBITS] = NBITS'(feat[f]);
        for (int s = 0; s < SUP_WIDTH; s++) begin
            bus.in_alpha[s*NBITS +: NBITS] = NBITS'(alpha[s]);
            for (int f = 0; f < F_WIDTH; f++)
                bus.in_support[(s*F_WIDTH + f)*NBITS +: NBITS] = NBITS'(sup[s][f]);
        end
        bus.in_intercept = S_W'(icpt);
        bus.in_nsup      = NSUP_W'(n);
        bus.fin_valid    = 1'b1;
        exp_sc[c]        = ref_score(n, icpt);
        @(posedge clk);
        #1;
        bus.fin_valid = 1'b0;
        scramble();
    endtask

    // Called right after the last class is accepted; checks the result beat,
    // optionally stalls it (with ignored fin_valid pulses) and completes it.
    task automatic finish_frame(input int n_last, input int hold, input bit pulse);
        int k;
        k = 0;
        do begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end while (!bus.dout_valid && k < 100);
        chk("latency", k, ref_latency(n_last));
        chk("score0", dut_score(0), exp_sc[0]);
        chk("score1", dut_score(1), exp_sc[1]);
        chk("labels", int'(bus.dout_labels), exp_labels());
        if (hold > 0) begin
            bus.dout_ready = 1'b0;
            for (int i = 0; i < hold; i++) begin
                if (pulse) begin
                    bus.fin_valid = i[0];
                    scramble();
                end
                @(posedge clk);
                @(negedge clk);
            end
            bus.fin_valid = 1'b0;
            chk("hold_valid", int'(bus.dout_valid), 1);
            chk("hold_fin_ready", int'(bus.fin_ready), 0);
            chk("hold_score0", dut_score(0), exp_sc[0]);
            chk("hold_score1", dut_score(1), exp_sc[1]);
            chk("hold_labels", int'(bus.dout_labels), exp_labels());
            bus.dout_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        chk("post_hs_valid", int'(bus.dout_valid), 0);
        chk("post_hs_fin_ready", int'(bus.fin_ready), 1);
        chk("post_hs_busy", int'(bus.busy), 0);
        prev_sc1 = exp_sc[1];
    endtask

    task automatic rand_frame(input int hold, input bit pulse);
        int n0, n1;
        n0 = int'($urandom_range(7));
        n1 = int'($urandom_range(7));
        rand_data();
        send_beat(0, n0, int'($urandom_range(400)) - 200);
        chk("stale_slot1", dut_score(1), prev_sc1);
        rand_data();
        send_beat(1, n1, int'($urandom_range(400)) - 200);
        finish_frame(n1, hold, pulse);
    endtask

    initial begin
        int seen;
        rst            = 1'b1;
        bus.fin_valid  = 1'b0;
        bus.dout_ready = 1'b1;
        scramble();
        @(negedge clk);
        @(negedge clk);
        chk("rst_fin_ready", int'(bus.fin_ready), 1);
        chk("rst_dout_valid", int'(bus.dout_valid), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_labels", int'(bus.dout_labels), 0);
        chk("rst_score0", dut_score(0), 0);
        chk("rst_score1", dut_score(1), 0);
        rst = 1'b0;

        // Basic sample: feats (3,-2), s0=(1,1), s1=(2,0), nsup=2.
        rand_data();
        feat[0] = 3; feat[1] = -2;
        sup[0][0] = 1; sup[0][1] = 1;
        sup[1][0] = 2; sup[1][1] = 0;
        alpha[0] = 1; alpha[1] = -1;
        send_beat(0, 2, 0);
        chk("stale_slot1", dut_score(1), prev_sc1);
        seen = 0;
        while (!bus.fin_ready && seen < 50) begin
            @(negedge clk);
            seen++;
        end
        chk("busy_between_classes", int'(bus.busy), 1);
        alpha[0] = -1; alpha[1] = 1;
        send_beat(1, 2, 0);
        finish_frame(2, 0, 1'b0);
        chk("basic_const_score0", dut_score(0), -5);
        chk("basic_const_score1", dut_score(1), 5);
        chk("basic_const_labels", int'(bus.dout_labels), 2);

        // Tie: class-0 score plus intercept lands exactly on 0.
        alpha[0] = 1; alpha[1] = -1;
        send_beat(0, 2, 5);
        alpha[0] = -1; alpha[1] = 1;
        send_beat(1, 2, 0);
        finish_frame(2, 0, 1'b0);
        chk("tie_const_score0", dut_score(0), 0);
        chk("tie_const_labels", int'(bus.dout_labels), 2);

        // Zero support vectors on the last class: intercept only, latency 1.
        rand_data();
        send_beat(0, 3, -7);
        send_beat(1, 0, 3);
        finish_frame(0, 0, 1'b0);
        chk("nsup0_const_score1", dut_score(1), 3);
        chk("nsup0_const_label1", int'(bus.dout_labels[1]), 1);

        // Count above SUP_WIDTH clamps; P=3 gives two blocks with lanes unused.
        rand_data();
        send_beat(0, 7, 11);
        rand_data();
        send_beat(1, 7, -11);
        finish_frame(7, 0, 1'b0);

        // Extremes: everything at the most negative operand value.
        for (int f = 0; f < F_WIDTH; f++) feat[f] = -16;
        for (int s = 0; s < SUP_WIDTH; s++) begin
            alpha[s] = -16;
            for (int f = 0; f < F_WIDTH; f++) sup[s][f] = -16;
        end
        send_beat(0, SUP_WIDTH, 0);
        send_beat(1, SUP_WIDTH, 0);
        finish_frame(SUP_WIDTH, 0, 1'b0);
        chk("extreme_const_score0", dut_score(0), SUP_WIDTH*2*256*(-16));
        chk("extreme_const_score1", dut_score(1), SUP_WIDTH*2*256*(-16));
        chk("extreme_const_labels", int'(bus.dout_labels), 0);

        // Backpressure for 10 cycles with fin_valid pulses, then a clean frame.
        rand_frame(10, 1'b1);
        rand_frame(0, 1'b0);

        // Asynchronous reset between edges while the last class is in MAT2.
        rand_data();
        send_beat(0, 2, 9);
        rand_data();
        send_beat(1, 4, -9);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_dout_valid", int'(bus.dout_valid), 0);
        chk("abort_fin_ready", int'(bus.fin_ready), 1);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_score0", dut_score(0), 0);
        #1 rst = 1'b0;
        prev_sc1 = 0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.dout_valid) seen++;
        end
        chk("abort_no_beat", seen, 0);
        rand_frame(0, 1'b0);

        // Randomized frames with random output stalls.
        for (int i = 0; i < 15; i++) begin
            rand_frame(int'($urandom_range(3)), 1'($urandom_range(1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
